retire_trace_buf: RTL



---
 rtl/retire_trace_buf.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: circular history of retired instructions with FWFT read port.
// Optional macro TRACE_RD_FILTER_EN keeps only register-writing retirements (plus halts).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | retirements ignored, reads drain residual entries
// CAPTURE | qualifying retirements are recorded, oldest overwritten when full
// FROZEN  | halt seen; retirements ignored, reads drain, IDLE once empty
module retire_trace_buf #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             ret_valid,
    input  logic [XLEN-1:0]  ret_pc,
    input  logic [31:0]      ret_ir,
    input  logic             ret_we,
    input  logic [4:0]       ret_rd,
    input  logic [XLEN-1:0]  ret_wdata,
    input  logic             ret_halt,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [XLEN-1:0]  rd_pc,
    output logic [31:0]      rd_ir,
    output logic [4:0]       rd_rd,
    output logic             rd_we,
    output logic [XLEN-1:0]  rd_wdata,
    output logic [SEQ_W-1:0] rd_seq,
    output logic [CW-1:0]    count,
    output logic [15:0]      overflow_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } stateT;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    stateT            stateQ, stateD;
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [CW-1:0]    cntQ;
    logic [15:0]      ovfQ;
    logic [SEQ_W-1:0] seqQ;

    logic [XLEN-1:0]  memPc    [DEPTH];
    logic [31:0]      memIr    [DEPTH];
    logic [4:0]       memRd    [DEPTH];
    logic             memWe    [DEPTH];
    logic [XLEN-1:0]  memWdata [DEPTH];
    logic [SEQ_W-1:0] memSeq   [DEPTH];

    logic filterPass;
    logic isFull;
    logic isEmpty;
    logic doPop;
    logic doPush;
    logic seqAdv;
    logic dropOldest;

    always_comb begin
        filterPass = 1'b1;
`ifdef TRACE_RD_FILTER_EN
        filterPass = ret_halt | (ret_we & (ret_rd != 5'd0));
`endif
        isFull     = (cntQ == FULL_CNT);
        isEmpty    = (cntQ == '0);
        doPop      = !isEmpty && rd_ready && !arm;
        // Sequence advances on every retirement in CAPTURE so filtered gaps stay visible.
        seqAdv     = (stateQ == CAPTURE) && ret_valid && !arm;
        doPush     = seqAdv && filterPass;
        dropOldest = doPush && isFull && !doPop;
    end

    always_comb begin
        stateD = stateQ;
        if (arm) begin
            stateD = CAPTURE;
        end else begin
            case (stateQ)
                IDLE:    stateD = IDLE;
                CAPTURE: if (ret_valid && ret_halt) stateD = FROZEN;
                FROZEN:  if (isEmpty || (doPop && !doPush && cntQ == ONE_CNT)) stateD = IDLE;
                default: stateD = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cntQ  <= '0;
            ovfQ  <= '0;
            seqQ  <= '0;
        end else if (arm) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cntQ  <= '0;
            ovfQ  <= '0;
            seqQ  <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop || dropOldest) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (doPush && !doPop && !isFull) begin
                cntQ <= cntQ + ONE_CNT;
            end else if (doPop && !doPush) begin
                cntQ <= cntQ - ONE_CNT;
            end
            if (dropOldest && (ovfQ != 16'hFFFF)) begin
                ovfQ <= ovfQ + 16'd1;
            end
            if (seqAdv) begin
                seqQ <= seqQ + SEQ_W'(1);
            end
        end
    end

    // Entry storage is deliberately left unreset; the cleared pointers make it unreachable.
    always_ff @(posedge clock) begin
        if (doPush) begin
            memPc[wrPtr]    <= ret_pc;
            memIr[wrPtr]    <= ret_ir;
            memRd[wrPtr]    <= ret_rd;
            memWe[wrPtr]    <= ret_we;
            memWdata[wrPtr] <= ret_wdata;
            memSeq[wrPtr]   <= seqQ;
        end
    end

    always_comb begin
        rd_valid     = !isEmpty;
        rd_pc        = memPc[rdPtr];
        rd_ir        = memIr[rdPtr];
        rd_rd        = memRd[rdPtr];
        rd_we        = memWe[rdPtr];
        rd_wdata     = memWdata[rdPtr];
        rd_seq       = memSeq[rdPtr];
        count        = cntQ;
        overflow_cnt = ovfQ;
        state        = stateQ;
    end

endmodule
